// File: rtl/murmur3_stream.sv
// Streaming MurmurHash3 x86_32: one 4-byte block mixed per cycle, then tail,
// length fold-in and fmix32 finalisation over three extra cycles.
module murmur3_stream #(
    parameter int LEN_W   = 32,
    parameter bit FMIX_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_bytes,
    input  logic [31:0]      in_seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_hash,
    output logic [LEN_W-1:0] out_len
);
    localparam logic [31:0] C1  = 32'hcc9e2d51;
    localparam logic [31:0] C2  = 32'h1b873593;
    localparam logic [31:0] C3  = 32'h85ebca6b;
    localparam logic [31:0] C4  = 32'hc2b2ae35;
    localparam logic [31:0] C_N = 32'he6546b64;

    typedef enum logic [2:0] {BODY, MIX1, MIX2, MIX3, OUT} state_t;

    state_t           state, state_nxt;
    logic [31:0]      h;
    logic [LEN_W-1:0] len;
    logic             first;
    logic             beat_hs;

    logic [31:0]      hb, k_in, k1, k2, hx, h_body;
    logic [LEN_W-1:0] len_body;
    logic             tail, zero;
    logic [31:0]      len32, m1a, m1, m2, m3;

    function automatic logic [31:0] rol(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    assign in_ready = (state == BODY);
    assign beat_hs  = in_valid & in_ready;

    if (LEN_W >= 32) begin : g_len_trunc
        assign len32 = len[31:0];
    end else begin : g_len_ext
        assign len32 = {{(32-LEN_W){1'b0}}, len};
    end

    // Body/tail step for the beat on the input; only committed on a handshake.
    always_comb begin
        hb       = first ? in_seed : h;
        k_in     = in_data;
        tail     = 1'b0;
        zero     = 1'b0;
        len_body = len + LEN_W'(4);
        if (in_last) begin
            case (in_bytes)
                3'd0: begin zero = 1'b1; len_body = len; end
                3'd1: begin k_in = {24'h0, in_data[7:0]};  tail = 1'b1; end
                3'd2: begin k_in = {16'h0, in_data[15:0]}; tail = 1'b1; end
                3'd3: begin k_in = {8'h0,  in_data[23:0]}; tail = 1'b1; end
                default: ;
            endcase
            if (tail) len_body = len + LEN_W'(in_bytes);
        end
        k1 = k_in * C1;
        k2 = rol(k1, 15) * C2;
        hx = hb ^ k2;
        if (zero)      h_body = hb;
        else if (tail) h_body = hx;
        else           h_body = rol(hx, 13) * 32'd5 + C_N;
    end

    always_comb begin
        m1a = h ^ len32;
        m1  = (m1a ^ (m1a >> 16)) * C3;
        m2  = (h ^ (h >> 13)) * C4;
        m3  = h ^ (h >> 16);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BODY:    if (beat_hs && in_last) state_nxt = FMIX_EN ? MIX1 : OUT;
            MIX1:    state_nxt = MIX2;
            MIX2:    state_nxt = MIX3;
            MIX3:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = BODY;
            default: state_nxt = BODY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BODY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h         <= '0;
            len       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_hash  <= '0;
            out_len   <= '0;
        end else begin
            case (state)
                BODY: if (beat_hs) begin
                    h     <= h_body;
                    len   <= len_body;
                    first <= in_last;
                    if (in_last && !FMIX_EN) begin
                        out_hash  <= h_body;
                        out_len   <= len_body;
                        out_valid <= 1'b1;
                    end
                end
                MIX1: h <= m1;
                MIX2: h <= m2;
                MIX3: begin
                    h         <= m3;
                    out_hash  <= m3;
                    out_len   <= len;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    len       <= '0;
                    first     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
